// File: rtl/gpr_wr_arb_pkg.sv
// Shared pipeline definitions: register-address/data widths and the zero register.
package gpr_wr_arb_pkg;

   localparam int REG_AW = 5;
   localparam int DATA_W = 32;

   localparam logic [REG_AW-1:0] ZERO_REG = '0;

endpackage

// File: rtl/gpr_wr_fifo.sv
// MDU result holding queue with per-entry valid bits, WAW kill-by-address and
// pending-read lookup for the two decode read ports.
module gpr_wr_fifo
   import gpr_wr_arb_pkg::*;
#(
   parameter int QDEPTH = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [REG_AW-1:0] push_wesel,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   input  logic              kill,
   input  logic [REG_AW-1:0] kill_wesel,
   input  logic [REG_AW-1:0] rs_addr,
   input  logic [REG_AW-1:0] rt_addr,
   output logic              full,
   output logic              empty,
   output logic              head_valid,
   output logic [REG_AW-1:0] head_wesel,
   output logic [DATA_W-1:0] head_data,
   output logic              pend_rs,
   output logic              pend_rt
);

   localparam int PW = $clog2(QDEPTH);
   localparam int CW = PW + 1;

   logic [QDEPTH-1:0] valid_q;
   logic [REG_AW-1:0] wesel_q [QDEPTH];
   logic [DATA_W-1:0] data_q  [QDEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [CW-1:0]     count;

   assign full       = (count == CW'(QDEPTH));
   assign empty      = (count == '0);
   assign head_valid = valid_q[rd_ptr];
   assign head_wesel = wesel_q[rd_ptr];
   assign head_data  = data_q[rd_ptr];

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
      end else begin
         for (int i = 0; i < QDEPTH; i++) begin
            if (kill && wesel_q[i] == kill_wesel) valid_q[i] <= 1'b0;
         end
         // A popped slot must drop out of the pending lookup immediately.
         if (pop) begin
            valid_q[rd_ptr] <= 1'b0;
            rd_ptr          <= rd_ptr + 1'b1;
         end
         // The pipeline write in the same cycle is younger, so it can kill the new entry.
         if (push) begin
            valid_q[wr_ptr] <= !(kill && push_wesel == kill_wesel);
            wr_ptr          <= wr_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: payload storage is not reset; the reset valid bits alone decide what is live.
   always_ff @(posedge clk) begin
      if (push) begin
         wesel_q[wr_ptr] <= push_wesel;
         data_q[wr_ptr]  <= push_data;
      end
   end

   // NOTE: every output of this block gets a default first, so no latch is inferred.
   always_comb begin
      pend_rs = 1'b0;
      pend_rt = 1'b0;
      for (int i = 0; i < QDEPTH; i++) begin
         if (valid_q[i] && wesel_q[i] == rs_addr) pend_rs = 1'b1;
         if (valid_q[i] && wesel_q[i] == rt_addr) pend_rt = 1'b1;
      end
      if (rs_addr == ZERO_REG) pend_rs = 1'b0;
      if (rt_addr == ZERO_REG) pend_rt = 1'b0;
   end

endmodule

// File: rtl/gpr_wr_arb.sv
// Single GPR write-port arbiter: pipeline write-back has absolute priority, MDU
// results wait in a small queue, and a starvation counter forces a bubble.
module gpr_wr_arb
   import gpr_wr_arb_pkg::*;
#(
   parameter int QDEPTH = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wb_we,
   input  logic [REG_AW-1:0] wb_wesel,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              md_valid,
   input  logic [REG_AW-1:0] md_wesel,
   input  logic [DATA_W-1:0] md_data,
   output logic              md_ready,
   input  logic [REG_AW-1:0] rs_addr,
   input  logic [REG_AW-1:0] rt_addr,
   output logic              pend_rs,
   output logic              pend_rt,
   output logic              gpr_we,
   output logic [REG_AW-1:0] gpr_wesel,
   output logic [DATA_W-1:0] gpr_wdata,
   output logic              starve
);

   logic              wb_win;
   logic              push;
   logic              pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic              head_valid;
   logic [REG_AW-1:0] head_wesel;
   logic [DATA_W-1:0] head_data;
   logic [1:0]        starve_cnt;
   logic [1:0]        starve_cnt_nxt;

   assign wb_win   = wb_we && (wb_wesel != ZERO_REG);
   assign md_ready = !fifo_full;
   assign push     = md_valid && md_ready && (md_wesel != ZERO_REG);
   assign pop      = !wb_win && !fifo_empty;

   gpr_wr_fifo #(
      .QDEPTH (QDEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .push_wesel (md_wesel),
      .push_data  (md_data),
      .pop        (pop),
      .kill       (wb_win),
      .kill_wesel (wb_wesel),
      .rs_addr    (rs_addr),
      .rt_addr    (rt_addr),
      .full       (fifo_full),
      .empty      (fifo_empty),
      .head_valid (head_valid),
      .head_wesel (head_wesel),
      .head_data  (head_data),
      .pend_rs    (pend_rs),
      .pend_rt    (pend_rt)
   );

   // Counts consecutive cycles the queue waited behind the pipeline; any pop or empty queue clears it.
   always_comb begin
      starve_cnt_nxt = 2'd0;
      if (!fifo_empty && wb_win) begin
         starve_cnt_nxt = (starve_cnt == 2'd3) ? 2'd3 : starve_cnt + 2'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt <= 2'd0;
         starve     <= 1'b0;
         gpr_we     <= 1'b0;
         gpr_wesel  <= '0;
         gpr_wdata  <= '0;
      end else begin
         starve_cnt <= starve_cnt_nxt;
         starve     <= (starve_cnt_nxt == 2'd3);
         if (wb_win) begin
            gpr_we    <= 1'b1;
            gpr_wesel <= wb_wesel;
            gpr_wdata <= wb_data;
         end else if (pop && head_valid) begin
            gpr_we    <= 1'b1;
            gpr_wesel <= head_wesel;
            gpr_wdata <= head_data;
         end else begin
            gpr_we    <= 1'b0;
         end
      end
   end

endmodule

// File: doc/gpr_wr_arb.md
GPR_WR_ARB -- requirements
Module: gpr_wr_arb

Interface
REQ-001 SHALL have ports: clk  in  1  clock, rising edge; rst  in  1  reset, asynchronous, active-high.
REQ-002 SHALL have ports: wb_we  in  1  pipeline write-back enable; wb_wesel  in  5  pipeline destination register; wb_data  in  32  pipeline write-back data.
REQ-003 SHALL have ports: md_valid  in  1  multiply/divide result valid; md_wesel  in  5  MDU destination register; md_data  in  32  MDU result; md_ready  out  1  MDU result accepted this cycle.
REQ-004 SHALL have ports: rs_addr  in  5  decode read address A; rt_addr  in  5  decode read address B; pend_rs  out  1  queued write to rs_addr pending; pend_rt  out  1  queued write to rt_addr pending.
REQ-005 SHALL have ports: gpr_we  out  1  register-file write enable; gpr_wesel  out  5  register-file write address; gpr_wdata  out  32  register-file write data; starve  out  1  pipeline must insert a write-back bubble.
REQ-006 SHALL have parameter: QDEPTH, default 2, MDU holding-queue depth (power of two, >= 2).

Function
REQ-007 SHALL own the single GPR write port; gpr_we/gpr_wesel/gpr_wdata SHALL be registered, one cycle after the winning request.
REQ-008 SHALL treat a request with destination 0 as no request (never written, never queued).
REQ-009 SHALL give the pipeline absolute priority: wb_we=1 with wb_wesel!=0 SHALL produce gpr_we=1, gpr_wesel=wb_wesel, gpr_wdata=wb_data next cycle.
REQ-010 SHALL hold MDU results in a FIFO of QDEPTH entries {valid, wesel, data}; md_ready = FIFO not full (registered occupancy), and push occurs when md_valid & md_ready.
REQ-011 SHALL not accept a push into a full FIFO even when a pop happens in the same cycle.
REQ-012 SHALL pop the head when the pipeline is not writing and the FIFO is non-empty; a valid head is written next cycle, an invalid (killed) head is discarded with gpr_we=0.
REQ-013 SHALL, on a pipeline write to register X, clear valid on every queued entry with wesel=X (WAW: the queued result is older), including an entry pushed in the same cycle.
REQ-014 SHALL allow push and pop in the same cycle when not full; occupancy is unchanged.
REQ-015 SHALL drive pend_rs = 1 iff rs_addr!=0 and any queued valid entry has wesel=rs_addr; pend_rt likewise; both combinational from FIFO state.
REQ-016 SHALL keep a 2-bit starvation counter: increment (saturating at 3) each cycle the FIFO is non-empty and the pipeline wins; clear on any pop or when the FIFO is empty.
REQ-017 SHALL assert starve (registered) while the counter equals 3; the pipeline responds with wb_we=0, and the next cycle pops the head.
REQ-018 SHALL wrap read/write pointers modulo QDEPTH, with occupancy kept in a separate counter of width log2(QDEPTH)+1.

Reset
REQ-019 SHALL, on rst, asynchronously clear gpr_we, gpr_wesel, gpr_wdata, starve, starvation counter, pointers, occupancy and all entry valid bits; md_ready=1 after reset, pend_rs=pend_rt=0.
REQ-020 SHALL discard queued MDU results when reset is asserted mid-operation; none are written after reset.

Structure
REQ-021 SHALL take the register-address width (5), data width (32) and the zero-register constant from the shared pipeline package.
REQ-022 SHALL place the FIFO storage, pointers and kill-by-address logic in one sub-module, gpr_wr_fifo; arbitration and starvation logic stay in gpr_wr_arb.

Verification
REQ-023 Test: idle pipeline, MDU pushes (r5, 0x11) -> gpr_we=1, gpr_wesel=5, gpr_wdata=0x11 two cycles after md_valid.
REQ-024 Test: pipeline writes every cycle and MDU pushes 2 results (r3, r4) -> md_ready=0 after the second push; starve=1 after 3 blocked cycles; after a bubble, r3 is written, then r4.
REQ-025 Test: MDU queues (r7, 0xAA), then the pipeline writes (r7, 0xBB) -> the queued entry is killed; final r7=0xBB, and no write of 0xAA appears.
REQ-026 Test: queued entry for r9 and rs_addr=9, rt_addr=0 -> pend_rs=1, pend_rt=0; after r9 is written, pend_rs=0.
REQ-027 Test: pipeline write with wb_wesel=0 and MDU push to r0 -> gpr_we stays 0 and occupancy stays 0.
REQ-028 Test: rst asserted with 2 entries queued -> outputs clear immediately, md_ready=1, and no write occurs after rst deasserts.
